// File: rtl/ghr_pkg.sv
// ghr_pkg: shared widths, history type and next-state selector for the speculative GHR
package ghr_pkg;
  localparam int GHR_W_DEF = 10;
  localparam int CKPT_DEPTH_DEF = 4;
  typedef logic [GHR_W_DEF-1:0] ghr_t;
  typedef enum logic [1:0] {GHR_HOLD, GHR_SHIFT, GHR_RESTORE} ghr_op_e;
endpackage

// File: rtl/ghr_ckpt_fifo.sv
// ghr_ckpt_fifo: in-order snapshot queue with flush; power-of-two depth so pointers wrap naturally
module ghr_ckpt_fifo
  import ghr_pkg::*;
#(
  parameter int W = GHR_W_DEF,
  parameter int DEPTH = CKPT_DEPTH_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [W-1:0]                   push_data,
  output logic [W-1:0]                   head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    head_d  = flush ? '0 : pop ? head_q + PW'(1) : head_q;
    tail_d  = flush ? '0 : push ? tail_q + PW'(1) : tail_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Snapshot storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end
  assign head_data = mem_q[head_q];
  assign count     = count_q;
  assign full      = count_q == CW'(DEPTH);
endmodule

// File: rtl/ghr_spec.sv
// ghr_spec: speculative global history with checkpoint recovery; GHR_COMMIT_EN adds o_ghr_commit
module ghr_spec
  import ghr_pkg::*;
#(
  parameter int GHR_W = GHR_W_DEF,
  parameter int CKPT_DEPTH = CKPT_DEPTH_DEF
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_pred_valid,
  input  logic                               i_pred_taken,
  output logic                               o_pred_ready,
  input  logic                               i_res_valid,
  input  logic                               i_res_taken,
  input  logic                               i_res_mispred,
  output logic [GHR_W-1:0]                   o_ghr,
  output logic [GHR_W-1:0]                   o_ghr_next,
  output logic [$clog2(CKPT_DEPTH+1)-1:0]    o_count
`ifdef GHR_COMMIT_EN
  ,
  output logic [GHR_W-1:0]                   o_ghr_commit
`endif
);
  logic [GHR_W-1:0] ghr_q, ghr_d, head_data;
  logic pred_fire, res_fire, mispred, full;
  ghr_op_e op;
  ghr_ckpt_fifo #(.W(GHR_W), .DEPTH(CKPT_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (pred_fire),
    .pop       (res_fire & ~i_res_mispred),
    .flush     (mispred),
    .push_data (ghr_q),
    .head_data (head_data),
    .count     (o_count),
    .full      (full)
  );
  // A mispredict anywhere in the cycle makes the same-cycle fetch wrong-path.
  always_comb begin
    pred_fire = i_pred_valid & o_pred_ready & ~(i_res_valid & i_res_mispred);
    res_fire  = i_res_valid & (o_count != '0);
    mispred   = res_fire & i_res_mispred;
    op        = mispred ? GHR_RESTORE : pred_fire ? GHR_SHIFT : GHR_HOLD;
    ghr_d     = op == GHR_RESTORE ? {head_data[GHR_W-2:0], i_res_taken}
              : op == GHR_SHIFT   ? {ghr_q[GHR_W-2:0], i_pred_taken} : ghr_q;
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) ghr_q <= '0;
    else          ghr_q <= ghr_d;
  end
  assign o_pred_ready = ~full;
  assign o_ghr        = ghr_q;
  assign o_ghr_next   = ghr_d;
`ifdef GHR_COMMIT_EN
  logic [GHR_W-1:0] commit_q, commit_d;
  always_comb commit_d = res_fire ? {commit_q[GHR_W-2:0], i_res_taken} : commit_q;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) commit_q <= '0;
    else          commit_q <= commit_d;
  end
  assign o_ghr_commit = commit_q;
`endif
endmodule

// File: tb/tb_ghr_spec.sv
// tb_ghr_spec: random and directed stimulus against a queue-based history model
module tb_ghr_spec;
  localparam int GW = 10;
  localparam int DEPTH = 4;
  logic i_clk = 0, i_reset = 0;
  logic i_pred_valid = 0, i_pred_taken = 0, i_res_valid = 0, i_res_taken = 0, i_res_mispred = 0;
  logic o_pred_ready;
  logic [GW-1:0] o_ghr, o_ghr_next;
  logic [2:0] o_count;
`ifdef GHR_COMMIT_EN
  logic [GW-1:0] o_ghr_commit;
`endif
  ghr_spec dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pred_valid(i_pred_valid), .i_pred_taken(i_pred_taken), .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .i_res_mispred(i_res_mispred),
    .o_ghr(o_ghr), .o_ghr_next(o_ghr_next), .o_count(o_count)
`ifdef GHR_COMMIT_EN
    , .o_ghr_commit(o_ghr_commit)
`endif
  );
  always #5 i_clk = ~i_clk;
  int total = 0, bad = 0;
  logic [GW-1:0] m_ghr = '0, m_commit = '0, g;
  logic [GW-1:0] mq[$];
  bit md[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic model_reset();
    m_ghr = '0;
    m_commit = '0;
    mq.delete();
    md.delete();
  endtask
  task automatic step(input bit pv, input bit pt, input bit rv, input bit rt, input bit rm);
    bit rdy, fp, fr;
    logic [GW-1:0] nxt;
    i_pred_valid = pv; i_pred_taken = pt; i_res_valid = rv; i_res_taken = rt; i_res_mispred = rm;
    rdy = mq.size() < DEPTH;
    fp  = pv && rdy && !(rv && rm);
    fr  = rv && mq.size() != 0;
    nxt = (fr && rm) ? {mq[0][GW-2:0], rt} : fp ? {m_ghr[GW-2:0], pt} : m_ghr;
    #1;
    chk("ready_pre", 32'(o_pred_ready), 32'(rdy));
    chk("ghr_next", 32'(o_ghr_next), 32'(nxt));
    @(posedge i_clk);
    if (fr) m_commit = {m_commit[GW-2:0], rt};
    if (fr && rm) begin
      mq.delete();
      md.delete();
    end else begin
      if (fr) begin
        void'(mq.pop_front());
        void'(md.pop_front());
      end
      if (fp) begin
        mq.push_back(m_ghr);
        md.push_back(pt);
      end
    end
    m_ghr = nxt;
    @(negedge i_clk);
    chk("ghr", 32'(o_ghr), 32'(m_ghr));
    chk("count", 32'(o_count), 32'(mq.size()));
    chk("ready", 32'(o_pred_ready), 32'(mq.size() < DEPTH));
`ifdef GHR_COMMIT_EN
    chk("commit", 32'(o_ghr_commit), 32'(m_commit));
    if (fr && rm) chk("ghr_eq_commit", 32'(o_ghr), 32'(o_ghr_commit));
`endif
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit pv, pt, rv, rt, rm;
    repeat (2) @(negedge i_clk);
    chk("rst_ghr", 32'(o_ghr), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_ready", 32'(o_pred_ready), 1);
    i_reset = 1;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("ttn_ghr", 32'(o_ghr), 32'h006);
    chk("ttn_count", 32'(o_count), 3);
    chk("snap0", 32'(mq[0]), 32'h000);
    chk("snap1", 32'(mq[1]), 32'h001);
    chk("snap2", 32'(mq[2]), 32'h003);
    step(0, 0, 1, 1, 0);
    chk("res_count", 32'(o_count), 2);
    chk("res_ghr", 32'(o_ghr), 32'h006);
    step(1, 1, 1, 0, 1);
    chk("mis_ghr", 32'(o_ghr), 32'h002);
    chk("mis_count", 32'(o_count), 0);
    chk("mis_ready", 32'(o_pred_ready), 1);
    repeat (4) step(1, 1'($urandom), 0, 0, 0);
    chk("full_ready", 32'(o_pred_ready), 0);
    g = o_ghr;
    step(1, 1, 0, 0, 0);
    chk("full_hold_ghr", 32'(o_ghr), 32'(g));
    chk("full_hold_count", 32'(o_count), 4);
    step(1, 1, 1, md[0], 0);
    chk("full_res_count", 32'(o_count), 3);
    chk("full_res_ghr", 32'(o_ghr), 32'(g));
    step(0, 0, 1, md[0], 0);
    g = o_ghr;
    step(1, 1, 1, md[0], 0);
    chk("pp_count", 32'(o_count), 2);
    chk("pp_ghr", 32'(o_ghr), 32'({g[GW-2:0], 1'b1}));
    step(0, 0, 1, !md[0], 1);
    g = o_ghr;
    step(0, 0, 1, 1, 0);
    chk("empty_ghr", 32'(o_ghr), 32'(g));
    chk("empty_count", 32'(o_count), 0);
    step(1, 1, 1, 0, 1);
    chk("empty_mis_ghr", 32'(o_ghr), 32'(g));
    for (int i = 0; i < 9; i++) begin
      step(1, 1'($urandom), 0, 0, 0);
      step(0, 0, 1, md[0], 0);
    end
    step(1, 1'($urandom), 0, 0, 0);
    step(1, 1'($urandom), 0, 0, 0);
    step(0, 0, 1, !md[0], 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #2;
    i_reset = 0;
    #1;
    chk("async_rst_ghr", 32'(o_ghr), 0);
    chk("async_rst_count", 32'(o_count), 0);
    chk("async_rst_ready", 32'(o_pred_ready), 1);
    model_reset();
    @(negedge i_clk);
    i_reset = 1;
    for (int i = 0; i < 400; i++) begin
      pv = $urandom_range(0, 3) != 0;
      pt = 1'($urandom);
      rv = $urandom_range(0, 2) == 0;
      rm = $urandom_range(0, 4) == 0;
      rt = md.size() != 0 ? (rm ? !md[0] : md[0]) : 1'($urandom);
      step(pv, pt, rv, rt, rm);
    end
    i_pred_valid = 0; i_res_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
